// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : branch_redirect_ctrl
// Brief   : 2-bit-counter BHT plus mispredict redirect sequencer for fetch.
//           Optional perf counters enabled by defining PERF_CNT_EN.
// Rev     : 1.0
// ============================================================================
module branch_redirect_ctrl #(
    parameter int         XLEN      = 64,
    parameter int         BHT_IDX_W = 6,
    parameter logic [1:0] CTR_RST   = 2'b01
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            d_valid,
    input  logic            d_is_branch,
    input  logic            d_is_jump,
    input  logic [XLEN-1:0] d_pc,
    input  logic            d_taken,
    input  logic [XLEN-1:0] d_target,
    input  logic            d_pred_taken,
    output logic            flush_f,
    output logic            stall_d,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic [31:0]     perf_br_cnt,
    output logic [31:0]     perf_mis_cnt
);

    localparam int c_BHT_DEPTH = 1 << BHT_IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_bht [c_BHT_DEPTH];
    logic [XLEN-1:0]        r_redirect_pc;

    logic                   w_resolve;
    logic                   w_taken;
    logic                   w_mis;
    logic                   w_train;
    logic                   w_load_pc;
    logic [BHT_IDX_W-1:0]   w_f_idx;
    logic [BHT_IDX_W-1:0]   w_d_idx;
    logic [1:0]             w_ctr_old;
    logic [1:0]             w_ctr_new;
    logic [XLEN-1:0]        w_corr_pc;
    logic                   w_unused_fpc;

    assign w_f_idx      = f_pc[BHT_IDX_W+1:2];
    assign w_d_idx      = d_pc[BHT_IDX_W+1:2];
    assign w_unused_fpc = ^{f_pc[XLEN-1:BHT_IDX_W+2], f_pc[1:0]};

    // Lookup reads the registered counter, so a same-cycle update is not bypassed.
    assign f_pred_taken = r_bht[w_f_idx][1];

    // Jumps are always taken; a jump flagged together with a branch acts as a jump.
    assign w_resolve = d_valid & (d_is_branch | d_is_jump) & (r_state == ST_IDLE);
    assign w_taken   = d_is_jump | d_taken;
    assign w_mis     = w_resolve & (w_taken != d_pred_taken);
    assign w_train   = w_resolve & d_is_branch & ~d_is_jump;
    assign w_corr_pc = w_taken ? d_target : (d_pc + XLEN'(4));

    assign w_ctr_old = r_bht[w_d_idx];

    always_comb begin
        w_ctr_new = w_ctr_old;
        if (w_taken) begin
            if (w_ctr_old != 2'b11) begin
                w_ctr_new = w_ctr_old + 2'd1;
            end
        end else begin
            if (w_ctr_old != 2'b00) begin
                w_ctr_new = w_ctr_old - 2'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < c_BHT_DEPTH; gi++) begin : g_bht
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_bht[gi] <= CTR_RST;
                end else if (w_train && (w_d_idx == BHT_IDX_W'(gi))) begin
                    r_bht[gi] <= w_ctr_new;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        flush_f        = 1'b0;
        stall_d        = 1'b0;
        redirect_valid = 1'b0;
        w_load_pc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mis) begin
                    flush_f     = 1'b1;
                    w_load_pc   = 1'b1;
                    w_state_nxt = ST_REDIR;
                end
            end
            ST_REDIR: begin
                flush_f        = 1'b1;
                stall_d        = 1'b1;
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Loaded only when entering REDIR, so the PC stays stable for the whole handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_redirect_pc <= '0;
        end else if (w_load_pc) begin
            r_redirect_pc <= w_corr_pc;
        end
    end

    assign redirect_pc = r_redirect_pc;

`ifdef PERF_CNT_EN
    logic [31:0] r_perf_br;
    logic [31:0] r_perf_mis;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_br  <= '0;
            r_perf_mis <= '0;
        end else begin
            if (w_resolve) begin
                r_perf_br <= r_perf_br + 32'd1;
            end
            if (w_mis) begin
                r_perf_mis <= r_perf_mis + 32'd1;
            end
        end
    end

    assign perf_br_cnt  = r_perf_br;
    assign perf_mis_cnt = r_perf_mis;
`else
    assign perf_br_cnt  = 32'd0;
    assign perf_mis_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
